hex_pwm_channel: RTL

//  Downstream consumer of one periodN/decodeN/hexN export triple from the nios2e system.
//  - Free-running counter of period cycles; PWM/blink output high for decode cycles of each period.
//  - Gates the CPU-written 7-seg+DP pattern so the digit blinks/dims.
//  - Top level instantiates 6-8 copies, one per display channel.

---
 rtl/hex_pwm_channel.sv | 94 +++++++++
 1 files changed

// File: rtl/hex_pwm_channel.sv
// hex_pwm_channel: per-digit PWM/blink gate for one HEX display.
// Free-running period counter; segments pass only during the on-phase.
module hex_pwm_channel #(
  parameter int          CNT_W = 28,
  parameter int          SEG_W = 8,
  parameter logic [SEG_W-1:0] BLANK = 8'hFF
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] decode_i,
  input  logic [SEG_W-1:0] hex_i,
  output logic [SEG_W-1:0] hex_o,
  output logic             pwm_o,
  output logic             wrap_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] period_sh, period_n;
  logic [CNT_W-1:0] decode_sh, decode_n;
  logic             pwm_n;
  logic             wrap_n;
  logic [SEG_W-1:0] hex_n;
  logic             last;

  // period_sh is never 0 while in RUN, so the -1 cannot underflow there
  assign last = (state == RUN) &&
                (cnt == period_sh - CNT_W'(1));

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    period_n = period_sh;
    decode_n = decode_sh;
    pwm_n    = 1'b0;
    wrap_n   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n    = '0;
        period_n = period_i;
        decode_n = decode_i;
        if (period_i != '0)
          state_n = RUN;
      end
      RUN: begin
        pwm_n  = (cnt < decode_sh);
        wrap_n = last;
        if (last) begin
          cnt_n    = '0;
          period_n = period_i;
          decode_n = decode_i;
          if (period_i == '0)
            state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    hex_n = pwm_n ? hex_i : BLANK;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      cnt       <= '0;
      period_sh <= '0;
      decode_sh <= '0;
      pwm_o     <= 1'b0;
      wrap_o    <= 1'b0;
      hex_o     <= BLANK;
    end else begin
      cnt       <= cnt_n;
      period_sh <= period_n;
      decode_sh <= decode_n;
      pwm_o     <= pwm_n;
      wrap_o    <= wrap_n;
      hex_o     <= hex_n;
    end
  end

endmodule
